// File: rtl/mux_scan_pkg.sv
// Shared mode constants and state encoding for the scanning channel multiplexer.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_sel_if.sv
// Channel inputs, sequencer controls and the tagged sample stream of mux_scan_sel.
// MUX_SCAN_SEL_MASK_EN adds the per-channel scan enable mask ch_mask.
interface mux_scan_sel_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SEL_W = $clog2(N);

  logic [N*W-1:0]   data_in;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             hold;
`ifdef MUX_SCAN_SEL_MASK_EN
  logic [N-1:0]     ch_mask;
`endif
  logic [W-1:0]     dout;
  logic [SEL_W-1:0] dout_ch;
  logic             dout_valid;
  logic             wrap;

`ifdef MUX_SCAN_SEL_MASK_EN
  modport master (
    output data_in, sel, mode, hold, ch_mask,
    input  dout, dout_ch, dout_valid, wrap
  );
  modport slave (
    input  data_in, sel, mode, hold, ch_mask,
    output dout, dout_ch, dout_valid, wrap
  );
`else
  modport master (
    output data_in, sel, mode, hold,
    input  dout, dout_ch, dout_valid, wrap
  );
  modport slave (
    input  data_in, sel, mode, hold,
    output dout, dout_ch, dout_valid, wrap
  );
`endif

endinterface

// File: rtl/mux_scan_next.sv
// Finds the next enabled channel after cur, searching circularly through mask.
// Combinational; wrap_flag is set when the search lands at or below cur.
module mux_scan_next #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N-1:0]     mask,
  output logic [SEL_W-1:0] next_idx,
  output logic             wrap_flag
);

  int   j;
  logic found;

  always_comb begin
    next_idx  = cur;
    wrap_flag = 1'b0;
    found     = 1'b0;
    j         = 0;
    // i = N revisits cur itself, so a single enabled channel re-selects itself and wraps.
    for (int i = 1; i <= N; i++) begin
      j = int'(cur) + i;
      if (j >= N) j = j - N;
      if (!found && mask[j]) begin
        found     = 1'b1;
        next_idx  = SEL_W'(j);
        wrap_flag = (j <= int'(cur));
      end
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel registered mux with MANUAL select and a dwell-timed SCAN sequencer; one clock latency.
// Optional MUX_SCAN_SEL_MASK_EN restricts the scan to channels enabled in ch_mask.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  mux_scan_sel_if.slave bus
);

  localparam int SEL_W = $clog2(N);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cur_cnt;
  logic [SEL_W-1:0] scan_ch, scan_nxt, cur_ch, adv_ch, ch_nxt, man_idx;
  logic [W-1:0]     dout_nxt, man_dat, scan_dat;
  logic             vld_nxt, wrap_nxt, adv_wrap;
  logic             sel_ok, sel_en, ch_en, any_en, dwell_end;

  // Coming out of MANUAL the sequencer always starts from channel 0, count 0.
  assign cur_cnt   = (state == ST_MANUAL) ? '0 : cnt;
  assign cur_ch    = (state == ST_MANUAL) ? '0 : scan_ch;
  assign dwell_end = (cur_cnt == CNT_LAST);

  assign sel_ok   = (int'(bus.sel) < N);
  assign man_idx  = sel_ok ? bus.sel : '0;
  assign man_dat  = bus.data_in[man_idx*W +: W];
  assign scan_dat = bus.data_in[cur_ch*W +: W];

`ifdef MUX_SCAN_SEL_MASK_EN
  assign any_en = |bus.ch_mask;
  assign ch_en  = bus.ch_mask[cur_ch];
  assign sel_en = bus.ch_mask[man_idx];

  mux_scan_next #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_next (
    .cur       (cur_ch),
    .mask      (bus.ch_mask),
    .next_idx  (adv_ch),
    .wrap_flag (adv_wrap)
  );
`else
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N - 1);

  assign any_en   = 1'b1;
  assign ch_en    = 1'b1;
  assign sel_en   = 1'b1;
  assign adv_wrap = (cur_ch == CH_LAST);
  assign adv_ch   = adv_wrap ? '0 : cur_ch + SEL_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_MANUAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_MANUAL;
    case (bus.mode)
      MODE_MANUAL: state_nxt = ST_MANUAL;
      MODE_SCAN:   state_nxt = ST_SCAN;
      default:     state_nxt = ST_MANUAL;
    endcase
  end

  always_comb begin
    dout_nxt = '0;
    ch_nxt   = '0;
    vld_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    cnt_nxt  = '0;
    scan_nxt = '0;
    case (state_nxt)
      ST_MANUAL: begin
        ch_nxt  = bus.sel;
        vld_nxt = sel_ok && sel_en;
        if (sel_ok) dout_nxt = man_dat;
      end
      default: begin
        ch_nxt   = cur_ch;
        cnt_nxt  = cur_cnt;
        scan_nxt = cur_ch;
        // An empty mask parks the sequencer and forces a zero, invalid sample.
        if (any_en) begin
          dout_nxt = scan_dat;
          if (!bus.hold) begin
            if (dwell_end) begin
              cnt_nxt  = '0;
              scan_nxt = adv_ch;
              vld_nxt  = ch_en;
              wrap_nxt = adv_wrap;
            end else begin
              cnt_nxt = cur_cnt + CNT_W'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      scan_ch        <= '0;
      bus.dout       <= '0;
      bus.dout_ch    <= '0;
      bus.dout_valid <= 1'b0;
      bus.wrap       <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      scan_ch        <= scan_nxt;
      bus.dout       <= dout_nxt;
      bus.dout_ch    <= ch_nxt;
      bus.dout_valid <= vld_nxt;
      bus.wrap       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: directed scenarios plus random traffic on an 8x1/DWELL=4 and a 5x3/DWELL=3 instance.
module tb_mux_scan_sel;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_scan_sel_if #(.N(8), .W(1)) bus_a ();
  mux_scan_sel_if #(.N(5), .W(3)) bus_b ();

  mux_scan_sel #(.N(8), .W(1), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_scan_sel #(.N(5), .W(3), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_chk   = 0;
  int n_fail  = 0;
  int steps_a = 0;
  int steps_b = 0;
  bit md, hd;
  bit mdl_a = 1'b1;
  logic [7:0]  da;
  logic [14:0] db;
  logic [2:0]  sa, sb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 'steps' counts un-held scan clocks since entering SCAN, so the
  // channel and dwell position follow directly from division by DWELL.
  task automatic model(input int n, input int dw, input int w, input logic [31:0] data,
                       input int sel, input bit mode_i, input bit hold_i, input bit rst_i,
                       inout int steps, output int e_dout, output int e_ch,
                       output bit e_vld, output bit e_wrap);
    int ch, pos;
    e_dout = 0; e_ch = 0; e_vld = 0; e_wrap = 0;
    if (rst_i) begin
      steps = 0;
    end else if (!mode_i) begin
      steps = 0;
      e_ch  = sel;
      if (sel < n) begin
        e_dout = int'((data >> (sel * w)) & ((32'd1 << w) - 1));
        e_vld  = 1;
      end
    end else begin
      ch     = (steps / dw) % n;
      pos    = steps % dw;
      e_ch   = ch;
      e_dout = int'((data >> (ch * w)) & ((32'd1 << w) - 1));
      if (!hold_i) begin
        e_vld  = (pos == dw - 1);
        e_wrap = e_vld && (ch == n - 1);
        steps++;
      end
    end
  endtask

  task automatic cyc();
    int ed_a, ec_a, ed_b, ec_b;
    bit ev_a, ew_a, ev_b, ew_b;
    bus_a.data_in = da; bus_a.sel = sa; bus_a.mode = md; bus_a.hold = hd;
    bus_b.data_in = db; bus_b.sel = sb; bus_b.mode = md; bus_b.hold = hd;
    model(8, 4, 1, 32'(da), int'(sa), md, hd, rst, steps_a, ed_a, ec_a, ev_a, ew_a);
    model(5, 3, 3, 32'(db), int'(sb), md, hd, rst, steps_b, ed_b, ec_b, ev_b, ew_b);
    @(posedge clk);
    #1;
    if (mdl_a) begin
      chk("a_dout",  32'(bus_a.dout),       32'(ed_a));
      chk("a_ch",    32'(bus_a.dout_ch),    32'(ec_a));
      chk("a_valid", 32'(bus_a.dout_valid), 32'(ev_a));
      chk("a_wrap",  32'(bus_a.wrap),       32'(ew_a));
    end
    chk("b_dout",  32'(bus_b.dout),       32'(ed_b));
    chk("b_ch",    32'(bus_b.dout_ch),    32'(ec_b));
    chk("b_valid", 32'(bus_b.dout_valid), 32'(ev_b));
    chk("b_wrap",  32'(bus_b.wrap),       32'(ew_b));
  endtask

  int exp_sw[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
  int nv;

  initial begin
    rst = 1'b1; md = 1'b0; hd = 1'b0;
    da = 8'hFF; db = '1; sa = '0; sb = '0;
`ifdef MUX_SCAN_SEL_MASK_EN
    bus_a.ch_mask = '1;
    bus_b.ch_mask = '1;
`endif
    repeat (2) cyc();
    chk("rst_valid", 32'(bus_a.dout_valid), 32'd0);
    chk("rst_dout",  32'(bus_a.dout),       32'd0);

    // Manual sweep over a fixed pattern.
    rst = 1'b0;
    da  = 8'b1010_0110;
    for (int s = 0; s < 8; s++) begin
      sa = 3'(s);
      cyc();
      chk("man_sweep", 32'(bus_a.dout), 32'(exp_sw[s]));
    end

    // One full scan revolution.
    md = 1'b1;
    da = 8'h5A;
    nv = 0;
    for (int k = 0; k < 32; k++) begin
      cyc();
      if (bus_a.dout_valid) nv++;
    end
    chk("scan_nvalid", 32'(nv), 32'd8);
    chk("wrap_clk32",  32'(bus_a.wrap), 32'd1);

    // Hold on channel 3 at dwell count 2.
    for (int k = 0; k < 32 && (steps_a % 32) != 14; k++) cyc();
    hd = 1'b1;
    repeat (5) begin
      cyc();
      chk("hold_ch",    32'(bus_a.dout_ch),    32'd3);
      chk("hold_valid", 32'(bus_a.dout_valid), 32'd0);
    end
    hd = 1'b0;
    cyc();
    cyc();
    chk("release_valid", 32'(bus_a.dout_valid), 32'd1);
    cyc();
    chk("release_next", 32'(bus_a.dout_ch), 32'd4);

    // Out-of-range select on N=5, then a mid-dwell mode bounce.
    md = 1'b0;
    sb = 3'd6;
    cyc();
    chk("b_sel6_valid", 32'(bus_b.dout_valid), 32'd0);
    chk("b_sel6_dout",  32'(bus_b.dout),       32'd0);
    md = 1'b1; cyc(); cyc();
    md = 1'b0; cyc();
    md = 1'b1; cyc();
    chk("b_restart_ch", 32'(bus_b.dout_ch), 32'd0);
    cyc(); cyc();
    chk("b_restart_valid", 32'(bus_b.dout_valid), 32'd1);

`ifdef MUX_SCAN_SEL_MASK_EN
    begin
      int seen[$];
      int wr_at;
      int exp_m[4] = '{0, 2, 7, 0};
      wr_at = -1;
      mdl_a = 1'b0;
      rst = 1'b1; md = 1'b0; cyc();
      rst = 1'b0; md = 1'b1;
      bus_a.ch_mask = 8'b1000_0101;
      for (int k = 0; k < 40 && seen.size() < 4; k++) begin
        cyc();
        if (bus_a.dout_valid) begin
          if (bus_a.wrap) wr_at = seen.size();
          seen.push_back(int'(bus_a.dout_ch));
        end
      end
      chk("mask_nvalid", 32'(seen.size()), 32'd4);
      if (seen.size() == 4)
        for (int k = 0; k < 4; k++) chk("mask_order", 32'(seen[k]), 32'(exp_m[k]));
      chk("mask_wrap_at", 32'(wr_at), 32'd2);
      bus_a.ch_mask = '0;
      repeat (8) begin
        cyc();
        chk("mask0_valid", 32'(bus_a.dout_valid), 32'd0);
      end
      bus_a.ch_mask = '1;
      mdl_a = 1'b1;
      rst = 1'b1; cyc();
      rst = 1'b0;
    end
`endif

    // Random traffic.
    repeat (600) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) md = ~md;
      hd = ($urandom_range(3) == 0);
      da = 8'($urandom);
      db = 15'($urandom);
      sa = 3'($urandom);
      sb = 3'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
